song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9: song ROM address width.
REQ-002 Parameter SONG2_BASE, default 256: ROM start address of song 2; song 1 starts at 0.
REQ-003 Parameter SONG_LEN, default 256: maximum note slots per song.
REQ-004 Parameter END_CODE, default 8'hFF: ROM end-of-song marker.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 mode  input  4  player mode: 0 sel_song1, 1 sel_song2, 2 play1, 3 play2, 4 ending, 5 play1_ps, 6 play1_pm, 7 play2_ps, 8 play2_pm.
REQ-008 beat_tick  input  1  one-cycle pulse at beat rate.
REQ-009 rom_data  input  8  note code from synchronous ROM, valid one cycle after rom_addr.
REQ-010 rom_addr  output  ADDR_W  registered ROM read address.
REQ-011 note  output  8  current note code to tone generator; 0 = rest/mute.
REQ-012 note_valid  output  1  high while note is sounding.
REQ-013 ending_sign  output  1  one-cycle pulse at song end, to the player FSM.
REQ-014 beat_count  output  10  notes played since song start; present only with BEAT_CNT_EN.

Function
REQ-015 States SHALL be IDLE, FETCH, LATCH, PLAY, PAUSED, DONE.
REQ-016 IDLE: mode 0/1 or any mode >8; rom_addr=0, note=0, note_valid=0.
REQ-017 IDLE and mode 2 or 3 -> FETCH with rom_addr = 0 (mode 2) or SONG2_BASE (mode 3).
REQ-018 FETCH always -> LATCH after one cycle; LATCH captures rom_data at its closing edge.
REQ-019 LATCH, rom_data != END_CODE -> PLAY; note=rom_data, note_valid=1.
REQ-020 LATCH, rom_data == END_CODE -> DONE; note=0, note_valid=0, ending_sign=1 for exactly one cycle.
REQ-021 Latency: note updates three cycles after the sampled beat_tick or play entry (tick cycle N -> FETCH N+1, LATCH N+2, note visible N+3).
REQ-022 PLAY, beat_tick=1 -> rom_addr+1, FETCH.
REQ-023 Wrap: PLAY, beat_tick=1 with rom_addr = song base+SONG_LEN-1 -> DONE with ending_sign pulse; address not incremented.
REQ-024 beat_tick is ignored in every state except PLAY; it is not queued.
REQ-025 Mode 5-8 in PLAY, FETCH or LATCH -> PAUSED; rom_addr held, note=0, note_valid=0.
REQ-026 PAUSED, mode 2/3 -> FETCH at the held rom_addr, re-fetching the interrupted note.
REQ-027 PAUSED or DONE, mode 0/1 -> IDLE; rom_addr cleared.
REQ-028 DONE holds, note muted, until mode 0/1.
REQ-029 Priority, same cycle: mode-driven transitions (pause/idle) beat beat_tick; pause plus tick leaves rom_addr unchanged.
REQ-030 Mode 4 received outside DONE -> DONE without an ending_sign pulse.

Reset
REQ-031 rst_n=0 at a clock edge -> IDLE, rom_addr=0, note=0, note_valid=0, ending_sign=0, beat_count=0; overrides all inputs.
REQ-032 Reset mid-song discards position; the next play entry restarts at the song base.

Configuration
REQ-033 Macro BEAT_CNT_EN defined: beat_count increments by one on each LATCH->PLAY transition, saturates at 1023, holds in PAUSED/DONE, and clears in IDLE.
REQ-034 BEAT_CNT_EN undefined: no beat_count port and no counter logic; all other behaviour identical.

Verification
REQ-035 Reset, mode=2, ROM[0]=8'h12 -> rom_addr=0, note=8'h12 with note_valid=1 on the third cycle after mode change.
REQ-036 Mode=3, ROM[256]=8'h05, ROM[257]=8'hFF, one tick -> note=8'h05, then ending_sign single pulse, note=0, state DONE.
REQ-037 Playing at addr 3, mode=5 with beat_tick the same cycle -> note=0, rom_addr stays 3; mode=2 -> ROM[3] re-fetched, note restored.
REQ-038 Mode=2, ROM[0..255] all non-END, 255 ticks then one more -> ending_sign at addr 255, no address 256 fetch.
REQ-039 rst_n=0 while playing addr 10 -> next cycle all outputs zero; mode=2 restarts at addr 0.
REQ-040 BEAT_CNT_EN: play 3 notes, pause, tick 5 times -> beat_count=3; mode=0 -> beat_count=0.

Source files
------------

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: player, ROM and tone-generator signals of song_sequencer; beat_count exists only with BEAT_CNT_EN
interface song_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic [3:0]        mode;
    logic              beat_tick;
    logic [7:0]        rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        note;
    logic              note_valid;
    logic              ending_sign;
`ifdef BEAT_CNT_EN
    logic [9:0]        beat_count;
    modport master (output mode, beat_tick, rom_data, input rom_addr, note, note_valid, ending_sign, beat_count);
    modport slave (input mode, beat_tick, rom_data, output rom_addr, note, note_valid, ending_sign, beat_count);
`else
    modport master (output mode, beat_tick, rom_data, input rom_addr, note, note_valid, ending_sign);
    modport slave (input mode, beat_tick, rom_data, output rom_addr, note, note_valid, ending_sign);
`endif
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a song ROM one note per beat with pause/resume and end-of-song detection.
// Defining BEAT_CNT_EN adds a saturating count of notes played since the song started.
module song_sequencer #(
    parameter int         ADDR_W     = 9,
    parameter int         SONG2_BASE = 256,
    parameter int         SONG_LEN   = 256,
    parameter logic [7:0] END_CODE   = 8'hFF
) (
    input logic             clk,
    input logic             rst_n,
    song_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, PAUSED, DONE} state_t;
    localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(SONG2_BASE);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(SONG2_BASE + SONG_LEN - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        note_q, note_d;
    logic              valid_q, valid_d;
    logic              end_q, end_d;
    logic              song_q, song_d;
    logic              m_sel, m_play, m_end, m_pause;
    assign m_sel   = bus.mode <= 4'd1;
    assign m_play  = bus.mode == 4'd2 || bus.mode == 4'd3;
    assign m_end   = bus.mode == 4'd4;
    assign m_pause = bus.mode >= 4'd5 && bus.mode <= 4'd8;
    // Next state, address and note; mode requests outrank beat_tick, and the last slot ends the song instead of advancing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        valid_d = valid_q;
        end_d   = 1'b0;
        song_d  = song_q;
        case (state_q)
            IDLE: begin
                if (m_play) begin
                    state_d = FETCH;
                    song_d  = bus.mode[0];
                    addr_d  = bus.mode[0] ? BASE2 : '0;
                end else if (m_end) begin
                    state_d = DONE;
                end
            end
            PAUSED: state_d = m_sel ? IDLE : m_end ? DONE : m_play ? FETCH : PAUSED;
            DONE: state_d = m_sel ? IDLE : DONE;
            default: begin
                if (m_sel) begin
                    state_d = IDLE;
                end else if (m_end) begin
                    state_d = DONE;
                end else if (m_pause) begin
                    state_d = PAUSED;
                end else if (state_q == FETCH) begin
                    state_d = LATCH;
                end else if (state_q == LATCH) begin
                    state_d = bus.rom_data == END_CODE ? DONE : PLAY;
                    end_d   = bus.rom_data == END_CODE;
                    note_d  = bus.rom_data;
                    valid_d = 1'b1;
                end else if (bus.beat_tick) begin
                    if (addr_q == (song_q ? LAST2 : LAST1)) begin
                        state_d = DONE;
                        end_d   = 1'b1;
                    end else begin
                        state_d = FETCH;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
        endcase
        if (state_d == IDLE) addr_d = '0;
        if (state_d == IDLE || state_d == PAUSED || state_d == DONE) begin
            note_d  = '0;
            valid_d = 1'b0;
        end
    end
    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            song_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            song_q  <= song_d;
        end
    end
    assign bus.rom_addr    = addr_q;
    assign bus.note        = note_q;
    assign bus.note_valid  = valid_q;
    assign bus.ending_sign = end_q;
`ifdef BEAT_CNT_EN
    logic [9:0] cnt_q, cnt_d;
    // Count notes entering PLAY, saturating at 1023; cleared whenever the player goes idle
    always_comb begin
        cnt_d = state_d == IDLE ? '0 : (state_q == LATCH && state_d == PLAY && cnt_q != 10'd1023) ? cnt_q + 10'd1 : cnt_q;
    end
    // Beat counter register
    always_ff @(posedge clk) begin
        cnt_q <= rst_n ? cnt_d : '0;
    end
    assign bus.beat_count = cnt_q;
`endif
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench; a song-level player model predicts every change of the sequencer outputs
module tb_song_sequencer;
    localparam int ADDR_W = 9;
    localparam int BASE2  = 256;
    localparam int LEN    = 256;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        note;
        logic              valid;
        logic              ends;
        logic [9:0]        cnt;
    } tup_t;
    typedef enum {M_IDLE, M_PLAY, M_PAUSED, M_DONE} mst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    logic [7:0] rom [512];
    int checks = 0;
    int errors = 0;
    tup_t exp_q[$];
    tup_t last;
    mst_t ms;
    int ma, msong, mcnt;
    logic [7:0] mnote;

    always #5 clk = ~clk;

    song_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
    song_sequencer #(.ADDR_W(ADDR_W), .SONG2_BASE(BASE2), .SONG_LEN(LEN), .END_CODE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    function automatic tup_t obs();
        tup_t t;
        t.addr  = bus.rom_addr;
        t.note  = bus.note;
        t.valid = bus.note_valid;
        t.ends  = bus.ending_sign;
`ifdef BEAT_CNT_EN
        t.cnt   = bus.beat_count;
`else
        t.cnt   = '0;
`endif
        return t;
    endfunction

    function automatic tup_t mk(int a, logic [7:0] n, logic v, logic e, int c);
        tup_t t;
        t.addr  = ADDR_W'(a);
        t.note  = n;
        t.valid = v;
        t.ends  = e;
`ifdef BEAT_CNT_EN
        t.cnt   = 10'(c);
`else
        t.cnt   = 10'(c & 0);
`endif
        return t;
    endfunction

    function automatic void chk(string name, tup_t got, tup_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got addr=%0d note=%02h valid=%b end=%b cnt=%0d, expected addr=%0d note=%02h valid=%b end=%b cnt=%0d",
                     name, got.addr, got.note, got.valid, got.ends, got.cnt, exp.addr, exp.note, exp.valid, exp.ends, exp.cnt);
        end
    endfunction

    // Expected output stream: only changes of the observable tuple are recorded
    function automatic void push(int a, logic [7:0] n, logic v, logic e);
        tup_t t = mk(a, n, v, e, mcnt);
        if (t !== last) begin
            exp_q.push_back(t);
            last = t;
        end
    endfunction

    function automatic int last_addr();
        return msong != 0 ? BASE2 + LEN - 1 : LEN - 1;
    endfunction

    function automatic void finish_song();
        ms = M_DONE;
        mnote = 8'h00;
        push(ma, 8'h00, 1'b0, 1'b1);
        push(ma, 8'h00, 1'b0, 1'b0);
    endfunction

    function automatic void latch();
        if (rom[ma] == 8'hFF) begin
            finish_song();
        end else begin
            ms = M_PLAY;
            mnote = rom[ma];
            if (mcnt < 1023) mcnt++;
            push(ma, mnote, 1'b1, 1'b0);
        end
    endfunction

    function automatic void model_tick();
        if (ms == M_PLAY) begin
            if (ma == last_addr()) finish_song();
            else begin
                ma++;
                push(ma, mnote, 1'b1, 1'b0);
                latch();
            end
        end
    endfunction

    function automatic void to_idle();
        ms = M_IDLE;
        ma = 0;
        mcnt = 0;
        mnote = 8'h00;
        push(0, 8'h00, 1'b0, 1'b0);
    endfunction

    function automatic void model_mode(int m);
        if (m <= 1) begin
            if (ms != M_IDLE) to_idle();
        end else if (m <= 3) begin
            if (ms == M_IDLE) begin
                msong = m - 2;
                ma = msong != 0 ? BASE2 : 0;
                push(ma, 8'h00, 1'b0, 1'b0);
                latch();
            end else if (ms == M_PAUSED) begin
                latch();
            end
        end else if (m == 4) begin
            if (ms != M_DONE) begin
                ms = M_DONE;
                mnote = 8'h00;
                push(ma, 8'h00, 1'b0, 1'b0);
            end
        end else if (m <= 8) begin
            if (ms == M_PLAY) begin
                ms = M_PAUSED;
                mnote = 8'h00;
                push(ma, 8'h00, 1'b0, 1'b0);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(int n);
        repeat (n) step();
    endtask

    task automatic cmd_mode(int m);
        bus.mode = 4'(m);
        model_mode(m);
        step();
        settle(6);
    endtask

    task automatic cmd_tick();
        bus.beat_tick = 1'b1;
        model_tick();
        step();
        bus.beat_tick = 1'b0;
        settle(6);
    endtask

    task automatic cmd_pause_tick(int m);
        bus.mode = 4'(m);
        bus.beat_tick = 1'b1;
        model_mode(m);
        step();
        bus.beat_tick = 1'b0;
        settle(6);
    endtask

    // Tick then pause on the very next cycle, catching the sequencer mid-fetch
    task automatic cmd_tick_pause();
        if (ms == M_PLAY && ma != last_addr()) begin
            ma++;
            push(ma, mnote, 1'b1, 1'b0);
            bus.beat_tick = 1'b1;
            step();
            bus.beat_tick = 1'b0;
            bus.mode = 4'd5;
            ms = M_PAUSED;
            mnote = 8'h00;
            push(ma, 8'h00, 1'b0, 1'b0);
            step();
            settle(6);
        end else begin
            cmd_tick();
            cmd_mode(5);
        end
    endtask

    task automatic cmd_reset();
        rst_n = 1'b0;
        bus.mode = 4'd0;
        bus.beat_tick = 1'b0;
        to_idle();
        step();
        rst_n = 1'b1;
        settle(3);
    endtask

    task automatic fill(int end_pct);
        for (int i = 0; i < 512; i++)
            rom[i] = ($urandom_range(0, 99) < end_pct) ? 8'hFF : {7'($urandom_range(0, 126)), 1'(i & 1)};
    endtask

    // Monitor: every change of the DUT outputs must match the next predicted change
    initial begin
        tup_t cur, prev;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = obs();
            if (mon_en && cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got addr=%0d note=%02h valid=%b end=%b cnt=%0d, expected no change",
                             cur.addr, cur.note, cur.valid, cur.ends, cur.cnt);
                end else begin
                    chk("output_seq", cur, exp_q.pop_front());
                end
            end
            prev = cur;
        end
    end

    initial begin
        bus.mode = 4'd0;
        bus.beat_tick = 1'b0;
        fill(0);
        rom[0] = 8'h12;
        rom[256] = 8'h05;
        rom[257] = 8'hFF;
        ms = M_IDLE;
        ma = 0;
        msong = 0;
        mcnt = 0;
        mnote = 8'h00;
        last = '0;
        settle(3);
        @(negedge clk);
        chk("reset_state", obs(), mk(0, 8'h00, 1'b0, 1'b0, 0));
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        // first note appears on the third cycle after play entry
        bus.mode = 4'd2;
        model_mode(2);
        step();
        step();
        @(negedge clk);
        chk("latency_before", obs(), mk(0, 8'h00, 1'b0, 1'b0, 0));
        step();
        @(negedge clk);
        chk("latency_note", obs(), mk(0, 8'h12, 1'b1, 1'b0, 1));
        settle(4);
        // pause with a simultaneous tick at addr 3, ignored ticks, resume, pause mid-fetch
        repeat (3) cmd_tick();
        cmd_pause_tick(5);
        repeat (5) cmd_tick();
        cmd_mode(2);
        cmd_tick_pause();
        repeat (2) cmd_tick();
        cmd_mode(3);
        cmd_mode(4);
        cmd_tick();
        cmd_mode(0);
        // song 2: one note then the end marker
        cmd_mode(3);
        cmd_tick();
        cmd_tick();
        cmd_mode(1);
        // full song 1 without an end marker wraps into DONE at the last slot
        fill(0);
        cmd_mode(2);
        repeat (256) cmd_tick();
        cmd_mode(0);
        // reset mid-song restarts from the song base
        cmd_mode(2);
        repeat (10) cmd_tick();
        cmd_reset();
        cmd_mode(2);
        cmd_mode(4);
        cmd_mode(0);
        // randomized command mix
        fill(4);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40) cmd_tick();
            else if (r < 48) cmd_mode($urandom_range(5, 8));
            else if (r < 53) cmd_pause_tick($urandom_range(5, 8));
            else if (r < 58) cmd_tick_pause();
            else if (r < 72) cmd_mode($urandom_range(2, 3));
            else if (r < 77) cmd_mode(4);
            else if (r < 97) begin
                if (ms == M_PLAY) cmd_tick();
                else if (ms == M_IDLE && r[0]) cmd_mode($urandom_range(9, 15));
                else cmd_mode($urandom_range(0, 1));
            end else cmd_reset();
        end
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predicted output changes never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
